// File: rtl/io_output_bank_if.sv
// CPU-side bus bundle for io_output_bank: address, data and strobes in;
// live port values, readback data and change pulses out.
interface io_output_bank_if #(
  parameter int NPORTS = 4,
  parameter int DATA_W = 32
);
  logic [31:0]              addr;
  logic [31:0]              datain;
  logic                     write_io_enable;
  logic                     read_io_enable;
  logic [NPORTS*DATA_W-1:0] out_port;
  logic [31:0]              rdata;
  logic [NPORTS-1:0]        port_updated;

  modport master (
    output addr, datain, write_io_enable, read_io_enable,
    input  out_port, rdata, port_updated
  );

  modport slave (
    input  addr, datain, write_io_enable, read_io_enable,
    output out_port, rdata, port_updated
  );
endinterface

// File: rtl/io_output_bank.sv
// Memory-mapped bank of output ports with WRITE/SET/CLEAR/TOGGLE ops selected by
// addr[9:8], optional shadow+commit double buffering, registered readback.
module io_output_bank #(
  parameter int         NPORTS = 4,
  parameter int         DATA_W = 32,
  parameter logic [7:0] BASE   = 8'h80,
  parameter int         DBUF   = 0
) (
  input  logic            io_clk,
  input  logic            reset,
  io_output_bank_if.slave bus
);

  localparam logic DB = (DBUF != 0);

  // Word address (addr[7:2]) of register slot idx; slot NPORTS is COMMIT.
  function automatic logic [5:0] word_of(input int idx);
    logic [7:0] a;
    a = BASE + 8'(4 * idx);
    return a[7:2];
  endfunction

  function automatic logic [DATA_W-1:0] apply_op(
    input logic [DATA_W-1:0] cur,
    input logic [DATA_W-1:0] d,
    input logic [1:0]        op
  );
    case (op)
      2'b00:   apply_op = d;
      2'b01:   apply_op = cur | d;
      2'b10:   apply_op = cur & ~d;
      2'b11:   apply_op = cur ^ d;
      default: apply_op = cur;
    endcase
  endfunction

  function automatic logic [31:0] zext(input logic [DATA_W-1:0] v);
    logic [31:0] r;
    r             = 32'd0;
    r[DATA_W-1:0] = v;
    return r;
  endfunction

  localparam logic [5:0] COMMIT_WORD = word_of(NPORTS);

  logic [DATA_W-1:0] r_live       [NPORTS];
  logic [DATA_W-1:0] r_shadow     [NPORTS];
  logic [31:0]       r_rdata;
  logic [NPORTS-1:0] r_updated;

  logic [DATA_W-1:0] w_live_nxt   [NPORTS];
  logic [DATA_W-1:0] w_shadow_nxt [NPORTS];
  logic [NPORTS-1:0] w_hit;
  logic              w_commit;
  logic              w_pending;
  logic [31:0]       w_rd_val;
  logic [DATA_W-1:0] w_d;
  logic [1:0]        w_op;
  logic              w_unused_bits;

  // Address decode, op evaluation, commit and readback selection.
  always_comb begin
    w_d       = bus.datain[DATA_W-1:0];
    w_op      = bus.addr[9:8];
    w_commit  = (bus.addr[7:2] == COMMIT_WORD);
    w_pending = 1'b0;
    w_rd_val  = 32'd0;
    w_hit     = {NPORTS{1'b0}};
    for (int i = 0; i < NPORTS; i++) begin
      w_hit[i]  = (bus.addr[7:2] == word_of(i));
      w_pending = w_pending | (DB & (r_shadow[i] != r_live[i]));
      w_rd_val  = w_rd_val | (w_hit[i] ? zext(DB ? r_shadow[i] : r_live[i]) : 32'd0);
      w_shadow_nxt[i] = (bus.write_io_enable && w_hit[i] && DB)
                        ? apply_op(r_shadow[i], w_d, w_op) : r_shadow[i];
      if (bus.write_io_enable && w_commit && DB) begin
        w_live_nxt[i] = r_shadow[i];
      end else if (bus.write_io_enable && w_hit[i] && !DB) begin
        w_live_nxt[i] = apply_op(r_live[i], w_d, w_op);
      end else begin
        w_live_nxt[i] = r_live[i];
      end
    end
    // Pending flag is only ever nonzero in double-buffered mode.
    w_rd_val = w_rd_val | {31'd0, w_commit & w_pending};
  end

  // Live/shadow registers, change pulses and readback register.
  always_ff @(posedge io_clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NPORTS; i++) begin
        r_live[i]   <= {DATA_W{1'b0}};
        r_shadow[i] <= {DATA_W{1'b0}};
      end
      r_rdata   <= 32'd0;
      r_updated <= {NPORTS{1'b0}};
    end else begin
      for (int i = 0; i < NPORTS; i++) begin
        r_live[i]    <= w_live_nxt[i];
        r_shadow[i]  <= w_shadow_nxt[i];
        r_updated[i] <= (w_live_nxt[i] != r_live[i]);
      end
      if (bus.read_io_enable) begin
        r_rdata <= w_rd_val;
      end else begin
        r_rdata <= r_rdata;
      end
    end
  end

  for (genvar g = 0; g < NPORTS; g++) begin : g_out
    assign bus.out_port[g*DATA_W +: DATA_W] = r_live[g];
  end

  assign bus.rdata         = r_rdata;
  assign bus.port_updated  = r_updated;
  assign w_unused_bits     = ^{bus.addr[31:10], bus.addr[1:0], bus.datain};

endmodule
